mac_dot_pipe: RTL and testbench



---
 rtl/mac_pkg.sv | 49 ++++
 rtl/mac_add_tree.sv | 26 ++
 rtl/mac_dot_pipe.sv | 125 ++++++++++++
 tb/tb_mac_dot_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths and arithmetic helpers for the MAC datapath and the PE array.
package mac_pkg;

   localparam int LANES_DEF = 4;
   localparam int A_W_DEF   = 8;
   localparam int B_W_DEF   = 8;
   localparam int ACC_W_DEF = 32;
   localparam int MAX_W     = 64;

   typedef struct packed {
      logic             sat;
      logic [MAX_W-1:0] sum;
   } sat_res_t;

   function automatic int p_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   function automatic int t_w(input int p, input int lanes);
      return p + $clog2(lanes);
   endfunction

   // Adds two sign-extended operands one bit wider than MAX_W, then clamps to acc_w bits.
   function automatic sat_res_t sat_add(input logic signed [MAX_W-1:0] acc_v,
                                        input logic signed [MAX_W-1:0] x,
                                        input int                      acc_w);
      logic signed [MAX_W:0] s;
      logic signed [MAX_W:0] one;
      logic signed [MAX_W:0] hi;
      logic signed [MAX_W:0] lo;
      sat_res_t              r;
      one    = '0;
      one[0] = 1'b1;
      s      = {acc_v[MAX_W-1], acc_v} + {x[MAX_W-1], x};
      hi     = (one <<< (acc_w - 1)) - one;
      lo     = -(one <<< (acc_w - 1));
      r.sat  = 1'b0;
      r.sum  = s[MAX_W-1:0];
      if (s > hi) begin
         r.sat = 1'b1;
         r.sum = hi[MAX_W-1:0];
      end else if (s < lo) begin
         r.sat = 1'b1;
         r.sum = lo[MAX_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_add_tree.sv
// Combinational signed adder tree; missing leaves of a non-power-of-two lane count are zero.
module mac_add_tree
   import mac_pkg::*;
#(
   parameter  int LANES = LANES_DEF,
   parameter  int P_W   = p_w(A_W_DEF, B_W_DEF),
   localparam int T_W   = t_w(P_W, LANES)
) (
   input  logic [LANES*P_W-1:0] prod,
   output logic signed [T_W-1:0] sum
);

   localparam int N = 1 << $clog2(LANES);

   logic signed [T_W-1:0] node [2*N-1];

   // Heap layout: leaves at N-1..2N-2, node k sums children 2k+1 and 2k+2.
   always_comb begin
      // NOTE: every node gets a default before the loops so no path leaves it unassigned.
      for (int i = 0; i < 2*N-1; i++) node[i] = '0;
      for (int i = 0; i < LANES; i++) node[N-1+i] = T_W'(signed'(prod[i*P_W +: P_W]));
      for (int k = N-2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
      sum = node[0];
   end

endmodule

// File: rtl/mac_dot_pipe.sv
// Three-stage signed dot-product accumulator: multiply, reduce, accumulate with framing.
module mac_dot_pipe
   import mac_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int SAT   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic [LANES*A_W-1:0]    a,
   input  logic [LANES*B_W-1:0]    b,
   output logic signed [ACC_W-1:0] acc,
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] out_acc,
   output logic                    sat_flag,
   output logic                    busy
);

   localparam int P_W = p_w(A_W, B_W);
   localparam int T_W = t_w(P_W, LANES);

   logic [LANES*P_W-1:0]    prod_c;
   logic [LANES*P_W-1:0]    s1_prod;
   logic                    s1_valid, s1_last;
   logic                    s2_valid, s2_last;
   logic signed [T_W-1:0]   tree_sum, s2_sum;
   logic signed [ACC_W-1:0] acc_nxt;
   logic                    sat_hit;
   logic                    in_frame;
   sat_res_t                sat_r;
   logic                    unused_sat;

   always_comb begin
      prod_c = '0;
      for (int i = 0; i < LANES; i++)
         prod_c[i*P_W +: P_W] = P_W'(signed'(a[i*A_W +: A_W])) * P_W'(signed'(b[i*B_W +: B_W]));
   end

   mac_add_tree #(
      .LANES (LANES),
      .P_W   (P_W)
   ) u_tree (
      .prod (s1_prod),
      .sum  (tree_sum)
   );

   // NOTE: non-blocking so each stage captures the previous stage's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_prod  <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_sum   <= '0;
      end else if (clr) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         s1_last  <= in_valid & in_last;
         if (in_valid) s1_prod <= prod_c;
         s2_valid <= s1_valid;
         s2_last  <= s1_valid & s1_last;
         if (s1_valid) s2_sum <= tree_sum;
      end
   end

   // The saturating path adds the full-width tree sum so overflow beyond ACC_W is still seen.
   always_comb begin
      sat_r = sat_add(MAX_W'(acc), MAX_W'(s2_sum), ACC_W);
      if (SAT != 0) begin
         acc_nxt = sat_r.sum[ACC_W-1:0];
         sat_hit = sat_r.sat;
      end else begin
         acc_nxt = acc + ACC_W'(s2_sum);
         sat_hit = 1'b0;
      end
   end

   assign unused_sat = ^sat_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         out_acc   <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         in_frame  <= 1'b0;
      end else if (clr) begin
         acc       <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         in_frame  <= 1'b0;
      end else begin
         out_valid <= s2_valid & s2_last;
         if (s2_valid) begin
            acc      <= s2_last ? '0 : acc_nxt;
            sat_flag <= in_frame ? (sat_flag | sat_hit) : sat_hit;
            in_frame <= ~s2_last;
            if (s2_last) out_acc <= acc_nxt;
         end
      end
   end

   assign busy = s1_valid | s2_valid;

`ifndef SYNTHESIS
   a_no_x_inputs : assert property (@(posedge clk) disable iff (!rst_n)
      in_valid |-> !$isunknown({a, b}));
   a_strobe_pairs : assert property (@(posedge clk) disable iff (!rst_n)
      out_valid |=> (!out_valid || $past(s2_last)));
   a_clr_zero_acc : assert property (@(posedge clk) disable iff (!rst_n)
      clr |=> (acc == '0));
`endif

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Scoreboard bench for mac_dot_pipe: a wrapping 32-bit instance plus 16-bit SAT=1/SAT=0 twins.
module tb_mac_dot_pipe;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        clr      = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last  = 1'b0;
   logic [31:0] a        = '0;
   logic [31:0] b        = '0;

   logic signed [31:0] acc, out_acc;
   logic               out_valid, sat_flag, busy;
   logic signed [15:0] acc_s, out_acc_s, acc_w, out_acc_w;
   logic               out_valid_s, sat_s, busy_s, out_valid_w, sat_w, busy_w;

   typedef struct {
      logic signed [31:0] val;
      int                 exp_edge;
   } exp_t;

   exp_t               sb_q[$];
   int                 n_checks = 0;
   int                 n_fails  = 0;
   int                 edge_cnt = 0;
   logic signed [31:0] model_acc = '0;
   logic signed [31:0] last_out  = '0;

   always #5 clk = ~clk;

   mac_dot_pipe u_dut (
      .clk (clk), .rst_n (rst_n), .clr (clr), .in_valid (in_valid), .in_last (in_last),
      .a (a), .b (b), .acc (acc), .out_valid (out_valid), .out_acc (out_acc),
      .sat_flag (sat_flag), .busy (busy)
   );

   mac_dot_pipe #(.ACC_W(16), .SAT(1)) u_dut_sat (
      .clk (clk), .rst_n (rst_n), .clr (clr), .in_valid (in_valid), .in_last (in_last),
      .a (a), .b (b), .acc (acc_s), .out_valid (out_valid_s), .out_acc (out_acc_s),
      .sat_flag (sat_s), .busy (busy_s)
   );

   mac_dot_pipe #(.ACC_W(16), .SAT(0)) u_dut_wrap (
      .clk (clk), .rst_n (rst_n), .clr (clr), .in_valid (in_valid), .in_last (in_last),
      .a (a), .b (b), .acc (acc_w), .out_valid (out_valid_w), .out_acc (out_acc_w),
      .sat_flag (sat_w), .busy (busy_w)
   );

   function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
      return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
   endfunction

   function automatic logic signed [31:0] dot4(input logic [31:0] av, input logic [31:0] bv);
      logic signed [31:0] s;
      s = '0;
      for (int i = 0; i < 4; i++)
         s = s + 32'(signed'(av[i*8 +: 8])) * 32'(signed'(bv[i*8 +: 8]));
      return s;
   endfunction

   // One clock; every strobe seen at the following negedge is matched against the queue.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      if (out_valid) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fails++;
            $display("FAIL sb_unexpected: out_valid=1 out_acc=%0d at edge %0d, no result pending",
                     out_acc, edge_cnt);
         end else begin
            e = sb_q.pop_front();
            if (out_acc !== e.val || edge_cnt != e.exp_edge) begin
               n_fails++;
               $display("FAIL sb_result: out_acc=%0d at edge %0d, expected %0d at edge %0d",
                        out_acc, edge_cnt, e.val, e.exp_edge);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic beat(input logic [31:0] av, input logic [31:0] bv,
                       input logic last, input logic expect_out);
      exp_t e;
      a = av; b = bv; in_valid = 1'b1; in_last = last;
      model_acc = model_acc + dot4(av, bv);
      if (last) begin
         if (expect_out) begin
            e.val      = model_acc;
            e.exp_edge = edge_cnt + 3;
            sb_q.push_back(e);
            last_out   = model_acc;
         end
         model_acc = '0;
      end
      cycle();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fails++;
         $display("FAIL sb_timeout: %0d results still pending, expected 0", sb_q.size());
      end
      idle(2);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({acc, out_acc, out_valid, sat_flag, busy} !== '0) begin
         n_fails++;
         $display("FAIL reset_state: acc=%0d out_acc=%0d out_valid=%b sat=%b busy=%b, expected all 0",
                  acc, out_acc, out_valid, sat_flag, busy);
      end
      n_checks++;
      if ({acc_s, out_acc_s, out_valid_s, sat_s, busy_s} !== '0) begin
         n_fails++;
         $display("FAIL reset_state_sat: acc=%0d out_acc=%0d sat=%b, expected all 0",
                  acc_s, out_acc_s, sat_s);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_beat();
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
      drain();
      n_checks++;
      if (out_acc !== 32'sd70 || acc !== 32'sd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL single_after: out_acc=%0d acc=%0d busy=%b out_valid=%b, expected 70 0 0 0",
                  out_acc, acc, busy, out_valid);
      end
   endtask

   task automatic test_two_beat();
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b1);
      beat(pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2), 1'b1, 1'b1);
      cycle();
      n_checks++;
      if (acc !== 32'sd70) begin
         n_fails++;
         $display("FAIL two_beat_mid_acc: acc=%0d, expected 70", acc);
      end
      drain();
      n_checks++;
      if (out_acc !== 32'sd62 || acc !== 32'sd0) begin
         n_fails++;
         $display("FAIL two_beat_hold: out_acc=%0d acc=%0d, expected 62 0", out_acc, acc);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] m128;
      m128 = pack4(-128, -128, -128, -128);
      beat(m128, m128, 1'b1, 1'b1);
      idle(2);
      n_checks++;
      if (out_valid_s !== 1'b1 || out_acc_s !== 16'sd32767 || sat_s !== 1'b1) begin
         n_fails++;
         $display("FAIL sat_pos: strobe=%b out_acc=%0d sat=%b, expected 1 32767 1",
                  out_valid_s, out_acc_s, sat_s);
      end
      n_checks++;
      if (out_valid_w !== 1'b1 || out_acc_w !== 16'sd0 || sat_w !== 1'b0) begin
         n_fails++;
         $display("FAIL wrap_pos: strobe=%b out_acc=%0d sat=%b, expected 1 0 0",
                  out_valid_w, out_acc_w, sat_w);
      end
      idle(1);
      n_checks++;
      if (sat_s !== 1'b1 || out_valid_s !== 1'b0 || out_acc_s !== 16'sd32767) begin
         n_fails++;
         $display("FAIL sat_sticky_idle: sat=%b strobe=%b out_acc=%0d, expected 1 0 32767",
                  sat_s, out_valid_s, out_acc_s);
      end
      // Saturating first beat, non-saturating second beat: the flag must stay up for the frame.
      beat(m128, m128, 1'b0, 1'b1);
      beat(pack4(-1, -1, -1, -1), pack4(1, 1, 1, 1), 1'b1, 1'b1);
      idle(2);
      n_checks++;
      if (out_acc_s !== 16'sd32763 || sat_s !== 1'b1 || out_acc_w !== -16'sd4 || sat_w !== 1'b0) begin
         n_fails++;
         $display("FAIL sat_two_beat: sat out_acc=%0d flag=%b wrap out_acc=%0d flag=%b, expected 32763 1 -4 0",
                  out_acc_s, sat_s, out_acc_w, sat_w);
      end
      beat(m128, pack4(127, 127, 127, 127), 1'b1, 1'b1);
      idle(2);
      n_checks++;
      if (out_acc_s !== 16'sh8000 || sat_s !== 1'b1 || out_acc_w !== 16'sd512) begin
         n_fails++;
         $display("FAIL sat_neg: sat out_acc=%0d flag=%b wrap out_acc=%0d, expected -32768 1 512",
                  out_acc_s, sat_s, out_acc_w);
      end
      beat(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b1);
      idle(2);
      n_checks++;
      if (out_acc_s !== 16'sd1 || sat_s !== 1'b0) begin
         n_fails++;
         $display("FAIL sat_clear_next: out_acc=%0d flag=%b, expected 1 0", out_acc_s, sat_s);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 8; k++)
         beat(pack4(k, k, k, k), pack4(1, 1, 1, 1), 1'b1, 1'b1);
      drain();
      // in_last without in_valid must neither start nor end anything.
      in_last = 1'b1;
      idle(3);
      in_last = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || acc !== 32'sd0 || out_acc !== 32'sd32) begin
         n_fails++;
         $display("FAIL b2b_after: busy=%b acc=%0d out_acc=%0d, expected 0 0 32", busy, acc, out_acc);
      end
   endtask

   task automatic test_clr();
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b0);
      clr = 1'b1; in_valid = 1'b1; in_last = 1'b1;
      a = pack4(1, 1, 1, 1); b = pack4(1, 1, 1, 1);
      cycle();
      clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      n_checks++;
      if (acc !== 32'sd0 || busy !== 1'b0 || out_acc !== last_out) begin
         n_fails++;
         $display("FAIL clr_after_last: acc=%0d busy=%b out_acc=%0d, expected 0 0 %0d",
                  acc, busy, out_acc, last_out);
      end
      idle(4);
      n_checks++;
      if (out_acc !== last_out || sat_flag !== 1'b0) begin
         n_fails++;
         $display("FAIL clr_hold: out_acc=%0d sat=%b, expected %0d 0", out_acc, sat_flag, last_out);
      end
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b0);
      idle(2);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      model_acc = '0;
      n_checks++;
      if (acc !== 32'sd0) begin
         n_fails++;
         $display("FAIL clr_mid_frame: acc=%0d, expected 0", acc);
      end
      beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_reset_mid_frame();
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b0);
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b0);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({acc, out_acc, out_valid, sat_flag, busy} !== '0) begin
         n_fails++;
         $display("FAIL reset_mid_frame: acc=%0d out_acc=%0d out_valid=%b sat=%b busy=%b, expected all 0",
                  acc, out_acc, out_valid, sat_flag, busy);
      end
      model_acc = '0;
      cycle();
      rst_n = 1'b1;
      beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
      drain();
      n_checks++;
      if (out_acc !== 32'sd70 || acc !== 32'sd0) begin
         n_fails++;
         $display("FAIL reset_recover: out_acc=%0d acc=%0d, expected 70 0", out_acc, acc);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_two_beat();
      test_saturation();
      test_back_to_back();
      test_clr();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
